// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG byte stuffer.
// JPEG_EOI_MARKER_EN adds the EOI_FF/EOI_D9 states that append the end-of-image marker.
package jpeg_pkg;

  localparam logic [7:0] BYTE_FF    = 8'hFF;
  localparam logic [7:0] BYTE_STUFF = 8'h00;
  localparam logic [7:0] EOI_LO     = 8'hD9;

`ifdef JPEG_EOI_MARKER_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_EMIT, ST_STUFF, ST_EOI_FF, ST_EOI_D9
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE, ST_LOAD, ST_EMIT, ST_STUFF
  } state_t;
`endif

  typedef struct packed {
    logic        last;
    logic [4:0]  bits;
    logic [31:0] data;
  } fifo_entry_t;

  // Final words get their unused tail filled with 1s; bits==0 means a full word.
  function automatic logic [31:0] pad_word(input fifo_entry_t e);
    logic [31:0] w;
    w = e.data;
    if (e.last && (e.bits != 5'd0)) w = e.data | (32'hFFFF_FFFF >> e.bits);
    return w;
  endfunction

  function automatic logic [2:0] byte_count(input fifo_entry_t e);
    logic [5:0] rounded;
    rounded = {1'b0, e.bits} + 6'd7;
    if (!e.last || (e.bits == 5'd0)) return 3'd4;
    return rounded[5:3];
  endfunction

endpackage

// File: rtl/jpeg_word_fifo.sv
// Synchronous word FIFO with registered pointers; one extra pointer bit separates full from empty.
// Write while full is accepted only when a read frees a slot in the same cycle.
module jpeg_word_fifo
  import jpeg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  fifo_entry_t wr_data,
  input  logic        rd_en,
  output fifo_entry_t rd_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr;
  fifo_entry_t mem [DEPTH];
  logic        do_wr, do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/jpeg_byte_stuffer.sv
// Serialises buffered 32-bit Huffman words into bytes, inserting 0x00 after every 0xFF; first byte 2 cycles after the strobe.
// Valid/ready output holds while stalled; JPEG_EOI_MARKER_EN appends an unstuffed FF D9 after the final word.
module jpeg_byte_stuffer
  import jpeg_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] JPEG_bitstream,
  input  logic        data_ready,
  input  logic        last_word,
  input  logic [4:0]  last_bits,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        overflow,
  output logic        busy
);

  state_t      state, state_nxt, done_state;
  fifo_entry_t wr_entry, rd_entry, entry_q;
  logic        fifo_full, fifo_empty, pop, push, xfer;
  logic [31:0] shift_q;
  logic [2:0]  count_q;
  logic        final_q;

  assign wr_entry = '{last: last_word, bits: last_bits, data: JPEG_bitstream};
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign push     = data_ready && (!fifo_full || pop);
  assign xfer     = out_valid && out_ready;
  assign busy     = !fifo_empty || (state != ST_IDLE);

  jpeg_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef JPEG_EOI_MARKER_EN
  assign done_state = final_q ? ST_EOI_FF : ST_IDLE;
`else
  assign done_state = ST_IDLE;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q  <= '0;
      shift_q  <= '0;
      count_q  <= '0;
      final_q  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (data_ready && fifo_full && !pop) overflow <= 1'b1;
      if (pop) entry_q <= rd_entry;
      if (state == ST_LOAD) begin
        shift_q <= pad_word(entry_q);
        count_q <= byte_count(entry_q);
        final_q <= entry_q.last;
      end else if ((state == ST_EMIT) && xfer) begin
        shift_q <= {shift_q[23:0], 8'h00};
        count_q <= count_q - 3'd1;
      end
    end
  end

  // Outputs come only from registered state, so they hold while out_ready is low.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    out_byte  = BYTE_STUFF;
    out_last  = 1'b0;
    case (state)
      ST_IDLE: if (!fifo_empty) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_EMIT;
      ST_EMIT: begin
        out_valid = 1'b1;
        out_byte  = shift_q[31:24];
`ifndef JPEG_EOI_MARKER_EN
        out_last  = final_q && (count_q == 3'd1) && (shift_q[31:24] != BYTE_FF);
`endif
        if (xfer) begin
          if (shift_q[31:24] == BYTE_FF) state_nxt = ST_STUFF;
          else if (count_q == 3'd1)      state_nxt = done_state;
        end
      end
      ST_STUFF: begin
        out_valid = 1'b1;
        out_byte  = BYTE_STUFF;
`ifndef JPEG_EOI_MARKER_EN
        out_last  = final_q && (count_q == 3'd0);
`endif
        if (xfer) state_nxt = (count_q != 3'd0) ? ST_EMIT : done_state;
      end
`ifdef JPEG_EOI_MARKER_EN
      ST_EOI_FF: begin
        out_valid = 1'b1;
        out_byte  = BYTE_FF;
        if (xfer) state_nxt = ST_EOI_D9;
      end
      ST_EOI_D9: begin
        out_valid = 1'b1;
        out_byte  = EOI_LO;
        out_last  = 1'b1;
        if (xfer) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jpeg_byte_stuffer.sv
// Bench for jpeg_byte_stuffer: queue-based byte-stream model, per-cycle compare, directed literal cases and random traffic.
module tb_jpeg_byte_stuffer;

  localparam int DEPTH = 8;
  localparam int AMAX  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] JPEG_bitstream = '0;
  logic        data_ready = 1'b0;
  logic        last_word = 1'b0;
  logic [4:0]  last_bits = '0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        overflow;
  logic        busy;

  always #5 clk = ~clk;

  jpeg_byte_stuffer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .JPEG_bitstream (JPEG_bitstream),
    .data_ready     (data_ready),
    .last_word      (last_word),
    .last_bits      (last_bits),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .overflow       (overflow),
    .busy           (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // expected stream entries are {word_end, last, byte}
  logic [9:0] exp_arr [AMAX];
  int         exp_wr = 0;
  int         exp_rd = 0;
  logic [8:0] got_arr [AMAX];
  int         got_cyc [AMAX];
  int         got_n = 0;
  int         words_sent = 0;
  int         words_done = 0;
  int         cyc = 0;
  bit         stall_prev = 0;
  logic [7:0] prev_byte;
  logic       prev_last;
  logic [9:0] e;
  logic [8:0] lit [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_exp(input logic [7:0] b, input bit lst);
    exp_arr[exp_wr % AMAX] = {1'b0, lst, b};
    exp_wr++;
  endtask

  // Reference: pad the tail of a final word with 1s, split into bytes, follow each FF with 00.
  task automatic push_word(input logic [31:0] w, input bit lw, input logic [4:0] lb);
    int          nbits;
    int          nb;
    logic [31:0] pw;
    logic [7:0]  b;
    nbits = (lw && lb != 0) ? int'(lb) : 32;
    pw = w;
    if (lw) for (int i = 0; i < 32 - nbits; i++) pw[i] = 1'b1;
    nb = lw ? (nbits + 7) / 8 : 4;
    for (int i = 0; i < nb; i++) begin
      b = pw[31 - 8*i -: 8];
      add_exp(b, 1'b0);
      if (b == 8'hFF) add_exp(8'h00, 1'b0);
    end
`ifdef JPEG_EOI_MARKER_EN
    if (lw) begin
      add_exp(8'hFF, 1'b0);
      add_exp(8'hD9, 1'b1);
    end
`else
    if (lw) exp_arr[(exp_wr - 1) % AMAX][8] = 1'b1;
`endif
    exp_arr[(exp_wr - 1) % AMAX][9] = 1'b1;
    words_sent++;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      exp_rd     = exp_wr;
      words_done = words_sent;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_byte", {out_last, out_byte}, {prev_last, prev_byte});
      end
      if (out_valid && out_ready) begin
        if (exp_rd == exp_wr) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_byte: got 0x%0h, expected no byte (t=%0t)", out_byte, $time);
        end else begin
          e = exp_arr[exp_rd % AMAX];
          exp_rd++;
          chk("stream_byte", {out_last, out_byte}, e[8:0]);
          got_arr[got_n % AMAX] = {out_last, out_byte};
          got_cyc[got_n % AMAX] = cyc;
          got_n++;
          if (e[9]) words_done++;
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_byte  = out_byte;
      prev_last  = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [31:0] w, input bit lw, input logic [4:0] lb, input bit accept);
    JPEG_bitstream = w;
    last_word      = lw;
    last_bits      = lb;
    data_ready     = 1'b1;
    if (accept) push_word(w, lw, lb);
    tick();
    data_ready = 1'b0;
    last_word  = 1'b0;
    last_bits  = '0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (exp_rd == exp_wr && !busy) break;
      tick();
    end
    chk({name, "_drained"}, exp_wr - exp_rd, 0);
    chk({name, "_idle"}, busy, 0);
  endtask

  task automatic check_lit(input int base, input string name);
    chk({name, "_count"}, got_n - base, lit.size());
    for (int i = 0; i < lit.size(); i++)
      chk({name, "_lit"}, got_arr[(base + i) % AMAX], lit[i]);
  endtask

  initial begin
    int          base;
    int          guard;
    logic [31:0] w;
    bit          lw;
    logic [4:0]  lb;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // first-byte latency and back-to-back bytes
    base = got_n;
    JPEG_bitstream = 32'h12345678;
    data_ready = 1'b1;
    push_word(32'h12345678, 0, 0);
    @(posedge clk);
    #2 data_ready = 1'b0;
    @(posedge clk);
    #1 chk("latency_edge1", out_valid, 0);
    @(posedge clk);
    #1 chk("latency_edge2", out_valid, 1);
    #1;
    drain("w12345678");
    lit = '{9'h012, 9'h034, 9'h056, 9'h078};
    check_lit(base, "w12345678");
    for (int i = 1; i < 4; i++)
      chk("consecutive", got_cyc[(base + i) % AMAX] - got_cyc[(base + i - 1) % AMAX], 1);

    base = got_n;
    strobe(32'hFF00FFAB, 0, 0, 1);
    drain("wFF00FFAB");
    lit = '{9'h0FF, 9'h000, 9'h000, 9'h0FF, 9'h000, 9'h0AB};
    check_lit(base, "wFF00FFAB");

    base = got_n;
    strobe(32'hA5000000, 1, 5'd4, 1);
    drain("final_A5");
`ifdef JPEG_EOI_MARKER_EN
    lit = '{9'h0AF, 9'h0FF, 9'h1D9};
`else
    lit = '{9'h1AF};
`endif
    check_lit(base, "final_A5");

    // stalls every other cycle on an all-FF word
    base = got_n;
    strobe(32'hFFFFFFFF, 0, 0, 1);
    for (int i = 0; i < 200; i++) begin
      if (exp_rd == exp_wr && !busy) break;
      out_ready = ~out_ready;
      tick();
    end
    out_ready = 1'b1;
    drain("wFFFFFFFF");
    lit = '{9'h0FF, 9'h000, 9'h0FF, 9'h000, 9'h0FF, 9'h000, 9'h0FF, 9'h000};
    check_lit(base, "wFFFFFFFF");

    // ten strobes against a stalled output: nine kept, tenth dropped
    out_ready = 1'b0;
    base = got_n;
    for (int i = 0; i < 10; i++)
      strobe({4{8'(i + 1)}}, 0, 0, i < 9);
    tick();
    chk("overflow_set", overflow, 1);
    out_ready = 1'b1;
    drain("overflow");
    chk("overflow_kept_bytes", got_n - base, 36);
    chk("overflow_last_byte", got_arr[(got_n - 1) % AMAX], 9'h009);
    chk("overflow_sticky", overflow, 1);
    rst = 1'b1;
    #1 chk("overflow_cleared", overflow, 0);
    tick();
    rst = 1'b0;
    tick();

    // reset while a byte is being presented
    out_ready = 1'b0;
    strobe(32'h11223344, 0, 0, 1);
    repeat (3) tick();
    chk("pre_reset_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_busy", busy, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    base = got_n;
    strobe(32'hCAFEBABE, 0, 0, 1);
    drain("after_reset");
    lit = '{9'h0CA, 9'h0FE, 9'h0BA, 9'h0BE};
    check_lit(base, "after_reset");

    // random traffic, never more words in flight than the FIFO holds
    guard = 0;
    while (words_sent < 200 + 17 && guard < 20000) begin
      guard++;
      out_ready = ($urandom_range(0, 3) != 0);
      if ((words_sent - words_done) < DEPTH && $urandom_range(0, 2) == 0) begin
        for (int k = 0; k < 4; k++)
          w[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        lw = ($urandom_range(0, 5) == 0);
        lb = 5'($urandom_range(0, 31));
        strobe(w, lw, lb, 1);
      end else begin
        tick();
      end
    end
    out_ready = 1'b1;
    drain("random");
    chk("random_no_overflow", overflow, 0);
    chk("random_words_done", words_done, words_sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_byte_stuffer.md
JPEG_BYTE_STUFFER -- requirements
Module: jpeg_byte_stuffer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of 38-bit input entries buffered (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port JPEG_bitstream  input  32  packed Huffman word from the Y entropy path, MSB first.
REQ-005 SHALL have port data_ready  input  1  one-cycle strobe qualifying JPEG_bitstream.
REQ-006 SHALL have port last_word  input  1  marks the strobed word as the final word of the image.
REQ-007 SHALL have port last_bits  input  5  valid bits in the final word; 0 means 32.
REQ-008 SHALL have port out_byte  output  8  stuffed output byte.
REQ-009 SHALL have port out_valid  output  1  out_byte valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer when out_valid and out_ready are both 1.
REQ-011 SHALL have port out_last  output  1  set with the final byte of the image.
REQ-012 SHALL have port overflow  output  1  sticky: a word was dropped.
REQ-013 SHALL have port busy  output  1  FIFO non-empty or FSM not IDLE.

Function
REQ-014 SHALL write {last_word, last_bits, JPEG_bitstream} to the FIFO on each clk edge with data_ready=1 and FIFO not full.
REQ-015 SHALL drop the word and set overflow when data_ready=1 and FIFO full with no pop that cycle; a simultaneous pop frees space and the write is accepted.
REQ-016 SHALL run FSM states IDLE, LOAD, EMIT, STUFF (plus EOI_FF, EOI_D9 per REQ-026).
REQ-017 IDLE: on FIFO non-empty, pop one entry -> LOAD; otherwise stay.
REQ-018 LOAD: latch word into shift register and set byte count = 4, or ceil(bits/8) for a final word -> EMIT.
REQ-019 For a final word, bits below last_bits SHALL be forced to 1 (JPEG 1-padding) before serialization.
REQ-020 EMIT: present shift[31:24], out_valid=1; on transfer shift left 8 and decrement count; a transferred 0xFF -> STUFF; otherwise count 0 -> IDLE, or stay in EMIT.
REQ-021 STUFF: present 0x00, out_valid=1; on transfer -> EMIT if count>0, else IDLE (or EOI_FF for a final word with the macro).
REQ-022 out_byte, out_valid and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 The first byte SHALL be valid exactly 2 cycles after the data_ready cycle when idle with an empty FIFO.
REQ-024 out_last SHALL assert only on the last byte of a final word, including its stuffed 0x00 if present, or on 0xD9 with the macro.

Reset
REQ-025 While rst=1: FIFO empty, FSM IDLE, out_byte=0x00, out_valid=0, out_last=0, overflow=0, busy=0; asserting rst mid-byte discards all pending data.

Configuration
REQ-026 Macro JPEG_EOI_MARKER_EN: when defined, after the final word's last byte (and its stuff byte) the FSM SHALL emit 0xFF (EOI_FF) then 0xD9 (EOI_D9, out_last=1) unstuffed, then IDLE; when undefined, the EOI states are absent and out_last follows REQ-024 on data bytes.

Structure
REQ-027 A shared package jpeg_pkg SHALL hold the FSM state enum, the constants BYTE_FF=8'hFF, BYTE_STUFF=8'h00, EOI_LO=8'hD9, and the 38-bit FIFO entry typedef.
REQ-028 The FIFO SHALL be a sub-module jpeg_word_fifo (sync, registered pointers, full/empty flags).

Verification
REQ-029 Word 0x12345678 strobed -> bytes 12,34,56,78 on 4 consecutive cycles with out_ready=1, first byte 2 cycles after the strobe.
REQ-030 Word 0xFF00FFAB -> FF,00,00,FF,00,AB.
REQ-031 Final word 0xA5000000, last_bits=4 -> single byte 0xAF with out_last=1; with JPEG_EOI_MARKER_EN -> AF,FF,D9 with out_last only on D9.
REQ-032 out_ready toggled 1/0 during word 0xFFFFFFFF -> 8 bytes FF,00 x4, each held stable while stalled.
REQ-033 FIFO_DEPTH=8, out_ready=0, 10 strobes -> 9 words retained (8 in FIFO, 1 in shift register), overflow=1 and held until rst.
REQ-034 rst asserted mid-EMIT -> out_valid=0 and busy=0 immediately; the next strobed word is emitted cleanly.
